// File: rtl/mem_trace_pkg.sv
// mem_trace_pkg
// Shared definitions for the memory-access trace recorder.
//   - trace mode constants (stop when full / overwrite oldest)
//   - width derivation helpers for the channel index and the trace entry
//   - bit offsets of the fields inside an entry {ts, ch, wr, addr}
package mem_trace_pkg;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int ent_width(input int ts_w, input int ch_w, input int addr_w);
        return ts_w + ch_w + 1 + addr_w;
    endfunction

    // Field offsets, LSB first: addr | wr | ch | ts
    function automatic int wr_pos(input int addr_w);
        return addr_w;
    endfunction

    function automatic int ch_lsb(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int ts_lsb(input int addr_w, input int ch_w);
        return addr_w + 1 + ch_w;
    endfunction

endpackage

// File: rtl/mem_trace_buffer_trace_rr_arbiter.sv
// trace_rr_arbiter
// Round-robin grant over NUM_CH requesters. The search starts at the channel
// after the last one that was actually granted (advance high).
// Ports:
//   clk        clock
//   rst_b      synchronous active-low reset
//   clear      synchronous flush, same effect as reset
//   req        per-channel request
//   advance    the current grant is consumed this edge
//   grant      one-hot grant
//   grant_idx  index of the granted channel
//   grant_any  some channel is granted
module trace_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clear,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_any
);

    logic [CH_W-1:0] last;
    int best;
    int best_d;
    int d;

    // Distance from the channel after 'last'; the closest requester wins.
    always_comb begin
        best      = 0;
        best_d    = NUM_CH;
        d         = 0;
        grant     = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (req[j]) begin
                d = (j + NUM_CH - int'(last) - 1) % NUM_CH;
                if (d < best_d) begin
                    best_d = d;
                    best   = j;
                end
            end
        end
        grant_any = |req;
        grant_idx = CH_W'(best);
        for (int j = 0; j < NUM_CH; j++) begin
            grant[j] = grant_any && (best == j);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b || clear) begin
            last <= CH_W'(NUM_CH - 1);
        end else if (advance && grant_any) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/mem_trace_buffer.sv
// mem_trace_buffer
// Memory-access trace recorder: filters per-channel access strobes by an
// address window, timestamps them, and queues them in a FIFO drained through
// a first-word-fall-through valid/ready port. Never back-pressures the source.
// Ports:
//   clk_i, rst_i (sync, active low), clear_i (sync flush)
//   enable_i     capture enable, timestamp runs only while high
//   wrap_mode_i  0 = stop when full, 1 = overwrite oldest
//   lo_i, hi_i   inclusive address window
//   ev_valid_i, ev_wr_i, ev_addr_i   per-channel access taps
//   out_valid_o, out_ready_i, out_data_o   entry {ts, ch, wr, addr}
//   count_o      FIFO occupancy
//   overflow_o   sticky, an entry was overwritten
//   drop_cnt_o   per-channel saturating drop counters
module mem_trace_buffer
    import mem_trace_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int TS_W   = 16,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = ch_width(NUM_CH),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int ENT_W  = ent_width(TS_W, CH_W, ADDR_W)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     wrap_mode_i,
    input  logic                     clear_i,
    input  logic [ADDR_W-1:0]        lo_i,
    input  logic [ADDR_W-1:0]        hi_i,
    input  logic [NUM_CH-1:0]        ev_valid_i,
    input  logic [NUM_CH-1:0]        ev_wr_i,
    input  logic [NUM_CH*ADDR_W-1:0] ev_addr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ENT_W-1:0]         out_data_o,
    output logic [PTR_W:0]           count_o,
    output logic                     overflow_o,
    output logic [NUM_CH*CNT_W-1:0]  drop_cnt_o
);

    logic                flush;
    logic [TS_W-1:0]     ts;
    logic [NUM_CH-1:0]   accept;
    logic [NUM_CH-1:0]   hold_valid;
    logic [ENT_W-1:0]    hold_data [NUM_CH];
    logic [CNT_W-1:0]    drop_cnt [NUM_CH];
    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_any;
    logic [ENT_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;
    logic                full;
    logic                pop;
    logic                push;
    logic                overwrite;

    assign flush = !rst_i || clear_i;

    // lo_i > hi_i makes the window empty without any special case.
    always_comb begin
        accept = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            accept[k] = ev_valid_i[k] && enable_i
                     && (ev_addr_i[k*ADDR_W +: ADDR_W] >= lo_i)
                     && (ev_addr_i[k*ADDR_W +: ADDR_W] <= hi_i);
        end
    end

    trace_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk_i),
        .rst_b     (rst_i),
        .clear     (clear_i),
        .req       (hold_valid),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign pop       = (count != '0) && out_ready_i;
    // A simultaneous pop frees a slot, so only stop mode with no pop blocks.
    assign push      = grant_any && !(full && (wrap_mode_i == MODE_STOP) && !pop);
    assign overwrite = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            ts         <= '0;
            hold_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_data[k] <= '0;
                drop_cnt[k]  <= '0;
            end
        end else begin
            if (enable_i) begin
                ts <= ts + TS_W'(1);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept[k]) begin
                    // A reg granted this edge is free for the new event.
                    if (!hold_valid[k] || (grant[k] && push)) begin
                        hold_valid[k] <= 1'b1;
                        hold_data[k]  <= {ts, CH_W'(k), ev_wr_i[k], ev_addr_i[k*ADDR_W +: ADDR_W]};
                    end else if (drop_cnt[k] != '1) begin
                        drop_cnt[k] <= drop_cnt[k] + CNT_W'(1);
                    end
                end else if (grant[k] && push) begin
                    hold_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush && push) begin
            mem[tail] <= hold_data[grant_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            // On overwrite tail == head, so the oldest entry is skipped.
            if (pop || overwrite) begin
                head <= head + PTR_W'(1);
            end
            if (overwrite) begin
                overflow_o <= 1'b1;
            end
            if (push && !pop && !full) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    assign out_valid_o = (count != '0);
    assign out_data_o  = (count != '0) ? mem[head] : '0;
    assign count_o     = count;

    always_comb begin
        drop_cnt_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            drop_cnt_o[k*CNT_W +: CNT_W] = drop_cnt[k];
        end
    end

endmodule

// File: tb/tb_mem_trace_buffer.sv
// tb_mem_trace_buffer
// Scoreboard bench for mem_trace_buffer: a queue-based reference model predicts
// FIFO contents, occupancy, overflow and drop counts; a negedge monitor checks
// the DUT against it and pops expected entries on each handshake.
module tb_mem_trace_buffer;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CNT_W  = 8;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ENT_W  = TS_W + CH_W + 1 + ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic                     wrap;
    logic                     clear;
    logic [ADDR_W-1:0]        lo;
    logic [ADDR_W-1:0]        hi;
    logic [NUM_CH-1:0]        ev_valid;
    logic [NUM_CH-1:0]        ev_wr;
    logic [NUM_CH*ADDR_W-1:0] ev_addr;
    logic                     out_valid;
    logic                     ready;
    logic [ENT_W-1:0]         out_data;
    logic [PTR_W:0]           count;
    logic                     overflow;
    logic [NUM_CH*CNT_W-1:0]  drop_cnt;

    mem_trace_buffer #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .wrap_mode_i (wrap),
        .clear_i     (clear),
        .lo_i        (lo),
        .hi_i        (hi),
        .ev_valid_i  (ev_valid),
        .ev_wr_i     (ev_wr),
        .ev_addr_i   (ev_addr),
        .out_valid_o (out_valid),
        .out_ready_i (ready),
        .out_data_o  (out_data),
        .count_o     (count),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int               m_ts;
    bit               m_hv [NUM_CH];
    logic [ENT_W-1:0] m_he [NUM_CH];
    int               m_last;
    int               m_count;
    bit               m_ovf;
    int               m_drop [NUM_CH];
    logic [ENT_W-1:0] exp_q [$];

    int vectors    = 0;
    int miscompares = 0;
    bit checking   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ENT_W-1:0] make_entry(input int ts, input int ch, input bit wr,
                                                    input logic [ADDR_W-1:0] a);
        logic [ENT_W-1:0] e;
        e = ENT_W'(a);
        e[ADDR_W] = wr;
        e = e | (ENT_W'(ch) << (ADDR_W + 1));
        e = e | (ENT_W'(ts) << (ADDR_W + 1 + CH_W));
        return e;
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        int g;
        int c;
        bit full;
        bit pop;
        bit push;
        logic [ADDR_W-1:0] a;
        if (!rst || clear) begin
            m_ts    = 0;
            m_last  = NUM_CH - 1;
            m_count = 0;
            m_ovf   = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_hv[k]   = 1'b0;
                m_drop[k] = 0;
            end
            exp_q.delete();
            return;
        end
        g = -1;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (m_last + i) % NUM_CH;
            if (g < 0 && m_hv[c]) g = c;
        end
        full = (m_count == DEPTH);
        pop  = (m_count != 0) && ready;
        push = (g >= 0) && !(full && !wrap && !pop);
        if (push) begin
            exp_q.push_back(m_he[g]);
            m_hv[g] = 1'b0;
            m_last  = g;
        end
        m_count = m_count + int'(push) - int'(pop);
        if (m_count > DEPTH) begin
            m_count = DEPTH;
            void'(exp_q.pop_front());
            m_ovf = 1'b1;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            a = ev_addr[k*ADDR_W +: ADDR_W];
            if (ev_valid[k] && enable && a >= lo && a <= hi) begin
                if (m_hv[k]) begin
                    if (m_drop[k] < (1 << CNT_W) - 1) m_drop[k]++;
                end else begin
                    m_hv[k] = 1'b1;
                    m_he[k] = make_entry(m_ts, k, ev_wr[k], a);
                end
            end
        end
        if (enable) m_ts = (m_ts + 1) % (1 << TS_W);
    endtask

    // Monitor: compares the DUT against the model and consumes on handshake.
    always @(negedge clk) begin
        if (checking) begin
            check("count", 64'(count), 64'(m_count));
            check("out_valid", 64'(out_valid), 64'(m_count != 0));
            check("overflow", 64'(overflow), 64'(m_ovf));
            for (int k = 0; k < NUM_CH; k++) begin
                check("drop_cnt", 64'(drop_cnt[k*CNT_W +: CNT_W]), 64'(m_drop[k]));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_data: got %0h, expected no entry at %0t", out_data, $time);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q[0]));
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        ev_valid = '0;
        ev_wr    = '0;
        ev_addr  = '0;
    endtask

    task automatic set_ev(input int k, input bit wr, input logic [ADDR_W-1:0] a);
        ev_valid[k] = 1'b1;
        ev_wr[k]    = wr;
        ev_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
    endtask

    task automatic seq_fill(input bit wrap_mode);
        do_reset();
        wrap  = wrap_mode;
        ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            idle_inputs();
            set_ev(0, 1'b0, ADDR_W'(32'h1000 + 4 * i));
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; wrap = 1'b0; clear = 1'b0;
        lo = '0; hi = '1; ready = 1'b0;
        idle_inputs();
        #1;
        step();
        step();
        rst = 1'b1;
        checking = 1'b1;
        check_all_zero("reset");

        // Single event on ch1 at ts=5, two-cycle latency
        enable = 1'b1;
        repeat (5) step();
        set_ev(1, 1'b1, 32'h20);
        step();
        idle_inputs();
        check("single_lat_n1", 64'(out_valid), 64'd0);
        step();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'({16'd5, 1'b1, 1'b1, 32'h20}));
        check("single_count", 64'(count), 64'd1);
        ready = 1'b1;
        step();
        check("single_drain", 64'(count), 64'd0);

        // Contention: both channels active three cycles running
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ev(0, 1'b0, ADDR_W'($urandom));
            set_ev(1, 1'b1, ADDR_W'($urandom));
            step();
        end
        idle_inputs();
        repeat (4) step();
        check("contention_drop0", 64'(drop_cnt[0 +: CNT_W]), 64'd1);
        check("contention_drop1", 64'(drop_cnt[CNT_W +: CNT_W]), 64'd1);

        // Address window filter
        do_reset();
        ready = 1'b0;
        lo = 32'h100; hi = 32'h1FF;
        begin
            logic [ADDR_W-1:0] fa [4];
            fa[0] = 32'hFC; fa[1] = 32'h100; fa[2] = 32'h1FF; fa[3] = 32'h200;
            for (int i = 0; i < 4; i++) begin
                idle_inputs();
                set_ev(0, 1'b0, fa[i]);
                step();
            end
        end
        idle_inputs();
        repeat (2) step();
        check("filter_count", 64'(count), 64'd2);
        lo = 32'h200; hi = 32'h100;
        for (int i = 0; i < 3; i++) begin
            set_ev(i % NUM_CH, 1'b0, ADDR_W'(32'h100 + 32'h80 * i));
            step();
            idle_inputs();
        end
        repeat (2) step();
        check("filter_empty_window", 64'(count), 64'd2);
        lo = '0; hi = '1;
        ready = 1'b1;
        repeat (3) step();

        // Stop mode, then push+pop while full
        seq_fill(1'b0);
        check("stop_count", 64'(count), 64'd16);
        check("stop_drop0", 64'(drop_cnt[0 +: CNT_W]), 64'd3);
        check("stop_overflow", 64'(overflow), 64'd0);
        check("stop_head", 64'(out_data[ADDR_W-1:0]), 64'h1004);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ev(0, 1'b1, ADDR_W'($urandom));
            step();
            check("full_pushpop_count", 64'(count), 64'd16);
            check("full_pushpop_ovf", 64'(overflow), 64'd0);
        end
        idle_inputs();
        repeat (20) step();
        ready = 1'b0;

        // Wrap mode
        seq_fill(1'b1);
        check("wrap_count", 64'(count), 64'd16);
        check("wrap_overflow", 64'(overflow), 64'd1);
        check("wrap_drop0", 64'(drop_cnt[0 +: CNT_W]), 64'd0);
        check("wrap_head", 64'(out_data[ADDR_W-1:0]), 64'h1014);
        ready = 1'b1;
        repeat (18) step();
        ready = 1'b0;
        wrap = 1'b0;

        // Reset and clear mid-trace
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_ev(i % NUM_CH, 1'b0, ADDR_W'($urandom));
            step();
            idle_inputs();
        end
        repeat (3) step();
        check("midtrace_count", 64'(count), 64'd8);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_all_zero("midrst");
        set_ev(0, 1'b1, 32'h44);
        step();
        idle_inputs();
        step();
        check("midrst_ts", 64'(out_data[ENT_W-1 -: TS_W]), 64'd0);
        for (int i = 0; i < 8; i++) begin
            set_ev(i % NUM_CH, 1'b0, ADDR_W'($urandom));
            step();
            idle_inputs();
        end
        repeat (3) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_all_zero("midclr");

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 40 == 0) begin
                lo = ADDR_W'($urandom_range(0, 160));
                hi = ADDR_W'($urandom_range(64, 255));
            end
            if (cyc % 90 == 0) wrap = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0);
            ready  = ($urandom_range(0, 3) == 0) ? 1'b0 : (cyc % 200 < 120);
            clear  = ($urandom_range(0, 149) == 0);
            rst    = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < NUM_CH; k++) begin
                ev_valid[k] = 1'($urandom_range(0, 1));
                ev_wr[k]    = 1'($urandom_range(0, 1));
                ev_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 255));
            end
            step();
        end
        rst = 1'b1; clear = 1'b0;
        idle_inputs();
        ready = 1'b1;
        repeat (25) step();
        check("final_drained", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
